lcd_frame_stats: RTL
====================

# lcd_frame_stats

Per-frame luminance statistics monitor on the LCD pixel stream, placed directly downstream of the filter pipe. It taps the filtered R/G/B values and pixel coordinates going into the LCD data controller. Over a power-of-two measurement window it accumulates mean, minimum and maximum luma and a count of pixels at or above a threshold. Results are latched at each vertical sync and presented on the seven-segment display and to the camera exposure logic.

## Interface

Parameters:
- WIN_X0, 64: window left edge, in active-area X coordinates.
- WIN_Y0, 112: window top edge, in active-area Y coordinates.
- WIN_W_LOG2, 9: window width is 2^WIN_W_LOG2 pixels.
- WIN_H_LOG2, 8: window height is 2^WIN_H_LOG2 lines.

Ports (N = WIN_W_LOG2 + WIN_H_LOG2):
- Clock  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  block enable.
- iVsync  in  1  LTM_VD, active-low vertical sync.
- iPixel_en  in  1  one-cycle strobe per displayed pixel.
- iCoord_X  in  10  pixel X coordinate.
- iCoord_Y  in  10  pixel Y coordinate.
- iRed, iGreen, iBlue  in  8 each  filtered pixel.
- iThreshold  in  8  bright-pixel threshold; sampled per pixel.
- oMean  out  8  latched mean luma.
- oMin  out  8  latched minimum luma.
- oMax  out  8  latched maximum luma.
- oBright_count  out  N+1  latched count of pixels with luma ≥ iThreshold.
- oFrame_ok  out  1  latched: counted pixels == 2^N exactly.
- oFrame_done  out  1  one-cycle pulse when results update.
- oFrame_count  out  16  number of latched frames; wraps at 16'hFFFF→0.

## Operation

- Luma computation: Y = (2R + 5G + B) >> 3. The sum is an 11-bit intermediate; the result is 8 bits, maximum 255.
- In-window test: iPixel_en && WIN_X0 ≤ X < WIN_X0+2^WIN_W_LOG2 && WIN_Y0 ≤ Y < WIN_Y0+2^WIN_H_LOG2.
- Accumulators:
  - sum: N+9 bits.
  - pix_cnt: N+1 bits, saturating.
  - bright_cnt: N+1 bits, saturating.
  - run_min: initialised to 8'hFF.
  - run_max: initialised to 8'h00.
- Frame edge: iVsync is registered once. An edge is prev=1 and cur=0 (falling).
- FSM states:
  - IDLE: Enable=0. Accumulators are held at their initial values, outputs hold their values, no pulses. Enable=1 moves to SYNC.
  - SYNC: accumulates, but the first frame edge does not latch. The edge clears the accumulators (the partial frame is discarded) and moves to RUN.
  - RUN: on each frame edge, latch results, pulse oFrame_done, increment oFrame_count, and clear the accumulators.
  - Enable=0 in any state returns to IDLE next cycle.
- Latched values:
  - oMean = sum >> N, saturated to 8'hFF if sum ≥ 2^(N+8).
  - oMin = run_min and oMax = run_max.
  - oBright_count = bright_cnt.
  - oFrame_ok = (pix_cnt == 2^N).
  - A frame with zero counted pixels latches oMean=0, oMin=FF, oMax=00, oFrame_ok=0.
- Reset values: all outputs 0, except oMin=8'hFF. The FSM resets to IDLE and the accumulators to their initial values.

## Timing

- Stage 1: registers luma, the in-window flag and the threshold compare.
- Stage 2: updates the accumulators.
- A pixel strobe at cycle t is reflected in the accumulators at t+2.
- Frame edge at registered-iVsync cycle e:
  - Outputs and oFrame_done are valid at e+1.
  - Latched values are the accumulators as of the end of cycle e−1.
  - A stage-2 update landing in cycle e is dropped and does not carry into the next frame.
- oFrame_done is high for exactly one cycle per latched frame.
- Reset mid-frame: takes effect immediately. After release the block is in IDLE and requires a fresh SYNC discard frame.
- Pixels at coordinates outside the window, or with iPixel_en=0, have no effect.

## Test plan

- Uniform frame: Enable, one discard frame, then full 512×256 window of R=G=B=100 with iThreshold=100.
  - Required: oMean=100, oMin=oMax=100, oBright_count=131072, oFrame_ok=1, oFrame_done one pulse, oFrame_count=1.
- Channel weighting: window split in half, R=255 (others 0) and B=255 (others 0).
  - Required: luma 63 and 31, oMin=31, oMax=63, oMean=47.
  - With iThreshold=40: oBright_count=65536.
- Partial and over-range frames:
  - Drop the last window line. Required: oFrame_ok=0, oMean=sum>>17 of the 130560 counted pixels.
  - Add pixels at X=WIN_X0−1 and X=WIN_X0+512. Required: ignored, counts unchanged.
- First-frame discard: assert Enable mid-frame. Required: the first vsync edge gives no pulse and oFrame_count stays 0; the second edge latches only the full frame.
- Reset mid-frame: assert Resetn=0 during accumulation. Required: all outputs 0, oMin=FF. After release and Enable, stats match the next complete frame only.
- Counter wrap: preload oFrame_count to 16'hFFFF (force). Required: the next latch gives 0.

Source files
------------

// File: rtl/lcd_frame_stats.sv
// Per-frame luma statistics (mean/min/max/bright count) over a power-of-two window of the LCD pixel stream.
// Latency: pixel strobe reaches the accumulators 2 cycles later; results appear 1 cycle after a registered vsync fall.
// Backpressure: none; this is a passive tap of the pixel stream and never stalls it.
module lcd_frame_stats #(
    parameter int WIN_X0     = 64,
    parameter int WIN_Y0     = 112,
    parameter int WIN_W_LOG2 = 9,
    parameter int WIN_H_LOG2 = 8
) (
    input  logic                                Clock,
    input  logic                                Resetn,
    input  logic                                Enable,
    input  logic                                iVsync,
    input  logic                                iPixel_en,
    input  logic [9:0]                          iCoord_X,
    input  logic [9:0]                          iCoord_Y,
    input  logic [7:0]                          iRed,
    input  logic [7:0]                          iGreen,
    input  logic [7:0]                          iBlue,
    input  logic [7:0]                          iThreshold,
    output logic [7:0]                          oMean,
    output logic [7:0]                          oMin,
    output logic [7:0]                          oMax,
    output logic [WIN_W_LOG2+WIN_H_LOG2:0]      oBright_count,
    output logic                                oFrame_ok,
    output logic                                oFrame_done,
    output logic [15:0]                         oFrame_count
);

    localparam int N  = WIN_W_LOG2 + WIN_H_LOG2;
    localparam int SW = N + 9;
    localparam int CW = N + 1;

    localparam logic [31:0] X_LO = 32'(WIN_X0);
    localparam logic [31:0] X_HI = 32'(WIN_X0 + (1 << WIN_W_LOG2));
    localparam logic [31:0] Y_LO = 32'(WIN_Y0);
    localparam logic [31:0] Y_HI = 32'(WIN_Y0 + (1 << WIN_H_LOG2));

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = {1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          acc_clr;
    logic          acc_en;
    logic          latch;

    logic [10:0]   luma_sum;
    logic [7:0]    luma;
    logic [31:0]   cx;
    logic [31:0]   cy;
    logic          in_win;

    logic          s1_vld;
    logic [7:0]    s1_luma;
    logic          s1_bright;

    logic          vs_cur;
    logic          vs_prev;
    logic          frame_edge;

    logic [SW-1:0] sum;
    logic [SW:0]   sum_ext;
    logic [SW-1:0] sum_nxt;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] bright_cnt;
    logic [7:0]    run_min;
    logic [7:0]    run_max;

    logic [15:0]   frame_count;

    // 2R + 5G + B fits in 11 bits (max 2040); >>3 keeps the result within 8 bits
    assign luma_sum = {2'b00, iRed, 1'b0}
                    + {1'b0, iGreen, 2'b00}
                    + {3'b000, iGreen}
                    + {3'b000, iBlue};
    assign luma     = luma_sum[10:3];

    assign cx     = {22'd0, iCoord_X};
    assign cy     = {22'd0, iCoord_Y};
    assign in_win = iPixel_en && (cx >= X_LO) && (cx < X_HI)
                              && (cy >= Y_LO) && (cy < Y_HI);

    assign frame_edge = vs_prev & ~vs_cur;

    // Saturating sum so a pathological stream with repeated coordinates cannot wrap
    assign sum_ext = {1'b0, sum} + (SW+1)'(s1_luma);
    assign sum_nxt = sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];

    // Stage 1: register luma, window membership and the per-pixel threshold compare
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1_vld    <= 1'b0;
            s1_luma   <= 8'd0;
            s1_bright <= 1'b0;
        end else begin
            s1_vld    <= in_win;
            s1_luma   <= luma;
            s1_bright <= (luma >= iThreshold);
        end
    end

    // Vsync is registered once; the previous sample lets us see the falling edge
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            vs_cur  <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_cur  <= iVsync;
            vs_prev <= vs_cur;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control; the first edge after enabling only discards the partial frame
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                acc_clr = 1'b1;
                if (Enable) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (!Enable) begin
                    state_nxt = IDLE;
                end else if (frame_edge) begin
                    acc_clr   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    acc_en = 1'b1;
                end
            end
            RUN: begin
                if (!Enable) begin
                    state_nxt = IDLE;
                end else if (frame_edge) begin
                    latch   = 1'b1;
                    acc_clr = 1'b1;
                end else begin
                    acc_en = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_clr   = 1'b1;
            end
        endcase
    end

    // Stage 2: accumulate; a clear on the edge cycle wins, so an update landing there is dropped
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sum        <= '0;
            pix_cnt    <= '0;
            bright_cnt <= '0;
            run_min    <= 8'hFF;
            run_max    <= 8'h00;
        end else if (acc_clr) begin
            sum        <= '0;
            pix_cnt    <= '0;
            bright_cnt <= '0;
            run_min    <= 8'hFF;
            run_max    <= 8'h00;
        end else if (acc_en && s1_vld) begin
            sum <= sum_nxt;
            if (pix_cnt != {CW{1'b1}}) begin
                pix_cnt <= pix_cnt + CNT_ONE;
            end
            if (s1_bright && (bright_cnt != {CW{1'b1}})) begin
                bright_cnt <= bright_cnt + CNT_ONE;
            end
            if (s1_luma < run_min) begin
                run_min <= s1_luma;
            end
            if (s1_luma > run_max) begin
                run_max <= s1_luma;
            end
        end
    end

    // Result latch on each counted frame edge; values hold between edges
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            oMean         <= 8'd0;
            oMin          <= 8'hFF;
            oMax          <= 8'h00;
            oBright_count <= '0;
            oFrame_ok     <= 1'b0;
            frame_count   <= 16'd0;
        end else if (latch) begin
            oMean         <= sum[SW-1] ? 8'hFF : sum[N+7:N];
            oMin          <= run_min;
            oMax          <= run_max;
            oBright_count <= bright_cnt;
            oFrame_ok     <= (pix_cnt == CNT_FULL);
            frame_count   <= frame_count + 16'd1;
        end
    end

    // One-cycle done pulse aligned with the freshly latched results
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            oFrame_done <= 1'b0;
        end else begin
            oFrame_done <= latch;
        end
    end

    assign oFrame_count = frame_count;

endmodule
